dac_spi_tx: RTL and testbench

Serial transmitter that drives an external dual-channel 12-bit SPI DAC with data words from the datapath, used for scope monitoring of phase currents, filtered values and angle. It is the write-side counterpart of the ADC serial reader. It accepts one ADC_N-wide, ADC_W-bit sample set per valid strobe, shifts one 16-bit frame per channel, then pulses LDAC so all channel outputs update simultaneously. The SCLK divider scheme matches the ADC interface.

---
 rtl/dac_spi_tx.sv | 190 +++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Dual-channel SPI DAC writer: one 16-bit frame per channel,
// then an LDAC strobe so every channel output updates together.
module dac_spi_tx #(
  parameter int N_CH    = 2,
  parameter int DW      = 12,
  parameter int CLK_DIV = 8,
  parameter int CS_GAP  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] din_data [N_CH],
  input  logic          din_val,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          dac_sclk,
  output logic          dac_csn,
  output logic          dac_mosi,
  output logic          dac_ldacn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_LDAC
  } state_t;

  localparam logic [7:0] DIV_TC  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_TC  = 8'(CS_GAP - 1);
  localparam logic [7:0] BIT_TC  = 8'd31;
  localparam logic [1:0] CH_LAST = 2'(N_CH - 1);

  state_t state_q, state_d;

  logic [7:0]    div_q, div_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    ch_q, ch_d;
  logic [1:0]    ch_inc;
  logic [15:0]   sr_q, sr_d;
  logic [15:0]   frame;
  logic [DW-1:0] shadow_q [N_CH];
  logic [DW-1:0] sel;

  logic sclk_q, sclk_d;
  logic csn_q, csn_d;
  logic mosi_q, mosi_d;
  logic ldacn_q, ldacn_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;
  logic tick;
  logic shadow_we;

  always_comb begin
    sel = shadow_q[0];
    for (int i = 1; i < N_CH; i++) begin
      if (ch_q == 2'(i)) sel = shadow_q[i];
    end
  end

  assign frame     = {ch_q, 2'b01, 12'(sel)};
  assign tick      = (div_q == DIV_TC);
  assign ch_inc    = ch_q + 2'd1;
  assign shadow_we = (state_q == S_IDLE) && din_val;

  always_comb begin
    state_d = state_q;
    div_d   = tick ? 8'd0 : div_q + 8'd1;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    csn_d   = csn_q;
    mosi_d  = mosi_q;
    ldacn_d = ldacn_q;
    done_d  = 1'b0;
    ovf_d   = din_val && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (din_val) begin
          ch_d    = 2'd0;
          csn_d   = 1'b0;
          mosi_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sr_d    = frame;
        div_d   = 8'd0;
        cnt_d   = 8'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          if (cnt_q == BIT_TC) begin
            sclk_d  = 1'b0;
            csn_d   = 1'b1;
            mosi_d  = 1'b0;
            div_d   = 8'd0;
            cnt_d   = 8'd0;
            state_d = S_GAP;
          end else begin
            sclk_d = ~sclk_q;
            cnt_d  = cnt_q + 8'd1;
            // falling edge: present the next bit
            if (sclk_q) begin
              mosi_d = sr_q[14];
              sr_d   = sr_q << 1;
            end
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == GAP_TC) begin
            cnt_d = 8'd0;
            div_d = 8'd0;
            if (ch_q != CH_LAST) begin
              ch_d    = ch_inc;
              csn_d   = 1'b0;
              mosi_d  = ch_inc[1];
              state_d = S_LOAD;
            end else begin
              ldacn_d = 1'b0;
              state_d = S_LDAC;
            end
          end
        end
      end
      S_LDAC: begin
        if (tick) begin
          ldacn_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ch_q    <= 2'd0;
      sr_q    <= 16'd0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b0;
      ldacn_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      mosi_q  <= mosi_d;
      ldacn_q <= ldacn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // shadow copy decouples frames from later din_data changes
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q <= din_data;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign dac_sclk  = sclk_q;
  assign dac_csn   = csn_q;
  assign dac_mosi  = mosi_q;
  assign dac_ldacn = ldacn_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: SPI bus monitor plus frame/timing model,
// default instance and a CLK_DIV=1 instance.
module tb_dac_spi_tx;

  localparam int CD0 = 8;
  localparam int CD1 = 1;
  localparam int CG  = 2;
  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] dd0 [2];
  logic [11:0] dd1 [2];
  logic        val0 = 1'b0;
  logic        val1 = 1'b0;
  logic [1:0]  busy, done, ovf, sclk, csn, mosi, ldacn;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_tx u0 (
    .clk(clk), .rstn(rstn), .din_data(dd0), .din_val(val0),
    .busy(busy[0]), .done(done[0]), .ovf(ovf[0]),
    .dac_sclk(sclk[0]), .dac_csn(csn[0]), .dac_mosi(mosi[0]),
    .dac_ldacn(ldacn[0])
  );

  dac_spi_tx #(.CLK_DIV(CD1), .CS_GAP(CG)) u1 (
    .clk(clk), .rstn(rstn), .din_data(dd1), .din_val(val1),
    .busy(busy[1]), .done(done[1]), .ovf(ovf[1]),
    .dac_sclk(sclk[1]), .dac_csn(csn[1]), .dac_mosi(mosi[1]),
    .dac_ldacn(ldacn[1])
  );

  // bus monitor: records what a DAC would see
  int frames[$], nbits[$], lows[$], gaps[$];
  int ldacs[$], dones[$], busys[$], ovfs[$];
  int bad_rise = 0;
  int bad_idle = 0;
  logic [1:0] ps = 2'b00, pc = 2'b11, pl = 2'b11;
  int last_rise [2] = '{0, 0};
  int fall_t [2] = '{0, 0};
  int rise_t [2] = '{-1, -1};
  int bits [2] = '{0, 0};
  int lcnt [2] = '{0, 0};
  int bcnt [2] = '{0, 0};
  logic [15:0] sh [2] = '{16'd0, 16'd0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int cd;
      cd = (i == 0) ? CD0 : CD1;
      if (csn[i] && sclk[i]) bad_idle++;
      if (sclk[i] && !ps[i]) begin
        if (bits[i] > 0 && cyc - last_rise[i] != 2 * cd) bad_rise++;
        last_rise[i] = cyc;
        sh[i] = {sh[i][14:0], mosi[i]};
        bits[i]++;
      end
      if (!csn[i] && pc[i]) begin
        if (rise_t[i] >= 0) gaps.push_back(cyc - rise_t[i]);
        fall_t[i] = cyc;
        bits[i] = 0;
        sh[i] = 16'd0;
      end
      if (csn[i] && !pc[i]) begin
        rise_t[i] = cyc;
        frames.push_back(int'(sh[i]));
        nbits.push_back(bits[i]);
        lows.push_back(cyc - fall_t[i]);
      end
      if (!ldacn[i]) lcnt[i]++;
      else if (!pl[i]) begin
        ldacs.push_back(lcnt[i]);
        lcnt[i] = 0;
      end
      if (busy[i]) bcnt[i]++;
      if (done[i]) begin
        dones.push_back(cyc);
        busys.push_back(bcnt[i]);
        bcnt[i] = 0;
        rise_t[i] = -1;
      end
      if (ovf[i]) ovfs.push_back(cyc);
      if (!rstn) begin
        bcnt[i] = 0;
        lcnt[i] = 0;
        rise_t[i] = -1;
      end
      ps[i] = sclk[i];
      pc[i] = csn[i];
      pl[i] = ldacn[i];
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // reference: frame layout and sequence timing from plain arithmetic
  function automatic int ref_frame(input int ch, input int d);
    return ch * 16384 + 4096 + (d % 4096);
  endfunction

  function automatic int ref_lat(input int cd);
    return NCH * (1 + 32 * cd + CG * cd) + cd + 1;
  endfunction

  int fp = 0, gp = 0, lp = 0, dp = 0, op = 0;

  task automatic check_seq(input int t0, input int a, input int b,
                           input int cd);
    chk("frame0", qget(frames, fp), ref_frame(0, a));
    chk("bits0", qget(nbits, fp), 16);
    chk("csn_low0", qget(lows, fp), 1 + 32 * cd);
    chk("frame1", qget(frames, fp + 1), ref_frame(1, b));
    chk("bits1", qget(nbits, fp + 1), 16);
    chk("csn_low1", qget(lows, fp + 1), 1 + 32 * cd);
    chk("csn_gap", qget(gaps, gp), CG * cd);
    chk("ldac_len", qget(ldacs, lp), cd);
    chk("done_lat", qget(dones, dp) - t0, ref_lat(cd));
    chk("busy_len", qget(busys, dp), ref_lat(cd) - 1);
    fp += 2;
    gp++;
    lp++;
    dp++;
  endtask

  // call at a negedge; din_val is high for the current cycle
  task automatic start(input int inst, input int a, input int b,
                       output int t0);
    t0 = cyc;
    if (inst == 0) begin
      dd0[0] = 12'(a); dd0[1] = 12'(b); val0 = 1'b1;
    end else begin
      dd1[0] = 12'(a); dd1[1] = 12'(b); val1 = 1'b1;
    end
    @(negedge clk);
    val0 = 1'b0;
    val1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dd0[i] = 12'($urandom);
      dd1[i] = 12'($urandom);
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (dones.size() < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(dones.size() >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, a, b, k, nl;
    for (int i = 0; i < 2; i++) begin
      dd0[i] = 12'd0;
      dd1[i] = 12'd0;
    end

    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_csn", int'(csn[0]), 1);
      chk("rst_sclk", int'(sclk[0]), 0);
      chk("rst_mosi", int'(mosi[0]), 0);
      chk("rst_ldacn", int'(ldacn[0]), 1);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      chk("rst_ovf", int'(ovf[0]), 0);
      chk("rst_csn1", int'(csn[1]), 1);
      val0 = 1'($urandom);
      val1 = 1'($urandom);
    end
    @(negedge clk);
    rstn = 1'b1;
    val0 = 1'b0;
    val1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy[0]), 0);
    chk("rst_no_ovf", ovfs.size(), 0);

    start(0, 'hABC, 'h123, t0);
    wait_done(dp + 1);
    check_seq(t0, 'hABC, 'h123, CD0);

    @(negedge clk);
    start(0, 'hABC, 'h123, t0);
    repeat (99) @(negedge clk);
    dd0[0] = 12'h555;
    dd0[1] = 12'h555;
    val0 = 1'b1;
    @(negedge clk);
    val0 = 1'b0;
    wait_done(dp + 1);
    repeat (20) @(negedge clk);
    chk("one_done", dones.size(), dp + 1);
    check_seq(t0, 'hABC, 'h123, CD0);
    chk("ovf_cyc", qget(ovfs, op) - t0, 101);
    op++;

    a = int'($urandom_range(0, 4095));
    b = int'($urandom_range(0, 4095));
    @(negedge clk);
    start(0, a, b, t0);
    k = 0;
    while (!done[0] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done", int'(done[0]), 1);
    start(0, 'h000, 'hFFF, t1);
    wait_done(dp + 2);
    check_seq(t0, a, b, CD0);
    check_seq(t1, 'h000, 'hFFF, CD0);

    a = int'($urandom_range(0, 4095));
    b = int'($urandom_range(0, 4095));
    @(negedge clk);
    start(0, a, b, t0);
    repeat (49) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_csn", int'(csn[0]), 1);
    chk("abort_sclk", int'(sclk[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    @(negedge clk);
    rstn = 1'b1;
    nl = ldacs.size();
    repeat (700) @(negedge clk);
    chk("abort_no_done", dones.size(), dp);
    chk("abort_no_ldac", ldacs.size(), nl);
    fp = frames.size();
    gp = gaps.size();
    lp = ldacs.size();

    for (int n = 0; n < 4; n++) begin
      a = int'($urandom_range(0, 4095));
      b = int'($urandom_range(0, 4095));
      repeat ($urandom_range(1, 5)) @(negedge clk);
      start(0, a, b, t0);
      wait_done(dp + 1);
      check_seq(t0, a, b, CD0);
    end

    @(negedge clk);
    start(1, 'hFFF, 'h000, t0);
    wait_done(dp + 1);
    check_seq(t0, 'hFFF, 'h000, CD1);
    a = int'($urandom_range(0, 4095));
    b = int'($urandom_range(0, 4095));
    @(negedge clk);
    start(1, a, b, t0);
    wait_done(dp + 1);
    check_seq(t0, a, b, CD1);

    repeat (5) @(negedge clk);
    chk("sclk_idle_low", bad_idle, 0);
    chk("sclk_period", bad_rise, 0);
    chk("ovf_total", ovfs.size(), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
